// File: rtl/prng_multi.sv
// prng_multi: multi-channel LFSR+CASR random word generator with a
// first-word-fall-through output buffer.
// Each channel emits LFSR[31:0] ^ CASR[31:0] of its current state.
// Optional repetition health check: define PRNG_HEALTH_CHECK_EN.
module prng_multi #(
  parameter int CHANNELS   = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int REP_LIMIT  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     load,
  input  logic [31:0]              seed,
  output logic [32*CHANNELS-1:0]   out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     health_fail
);

  localparam int DATA_W = 32 * CHANNELS;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;

  // Cellular automaton: rule 90 everywhere, rule 150 at cell 27.
  function automatic logic [36:0] casr_step(input logic [36:0] c);
    logic [36:0] n;
    n     = {c[35:0], c[36]} ^ {c[0], c[36:1]};
    n[27] = n[27] ^ c[27];
    return n;
  endfunction

  // Rotate-left LFSR with the outgoing top bit fed into taps 41, 20 and 1.
  function automatic logic [42:0] lfsr_step(input logic [42:0] l);
    logic [42:0] n;
    n     = {l[41:0], l[42]};
    n[41] = n[41] ^ l[42];
    n[20] = n[20] ^ l[42];
    n[1]  = n[1]  ^ l[42];
    return n;
  endfunction

  logic [CHANNELS-1:0][36:0] casr_q, casr_d;
  logic [CHANNELS-1:0][42:0] lfsr_q, lfsr_d;
  logic [DATA_W-1:0]         word;
  logic [DATA_W-1:0]         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      full, pop, step;
  logic                      hf_now, trip;

  assign full      = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid && out_ready;
  assign step      = enable && !load && !hf_now && (!full || pop);
  assign out_data  = out_valid ? mem_q[rd_q] : '0;
  assign health_fail = hf_now;

  // Concatenate the per-channel output words from the pre-step state.
  always_comb begin
    word = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      word[32*c +: 32] = lfsr_q[c][31:0] ^ casr_q[c][31:0];
    end
  end

  // Next generator state: seed load has priority over stepping.
  always_comb begin
    logic [31:0] sc;
    casr_d = casr_q;
    lfsr_d = lfsr_q;
    sc     = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      sc = seed ^ (c[31:0] * 32'h9E37_79B9);
      if (load) begin
        casr_d[c] = {5'h0, sc}  | 37'h1000_0000;
        lfsr_d[c] = {11'h0, sc} | 43'h1000_0000;
      end else if (step) begin
        casr_d[c] = casr_step(casr_q[c]);
        lfsr_d[c] = lfsr_step(lfsr_q[c]);
      end
    end
  end

  // Generator state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      casr_q <= {CHANNELS{37'h10000000}};
      lfsr_q <= {CHANNELS{43'h10000001}};
    end else begin
      casr_q <= casr_d;
      lfsr_q <= lfsr_d;
    end
  end

  // FIFO pointer and occupancy update; load or a health trip empties it.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (load || trip) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (step) wr_d = wr_q + PTR_W'(1);
      if (pop)  rd_d = rd_q + PTR_W'(1);
      case ({step, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // FIFO control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // FIFO storage; a full-and-popping write lands in the slot being vacated.
  always_ff @(posedge clk) begin
    if (step) mem_q[wr_q] <= word;
  end

`ifdef PRNG_HEALTH_CHECK_EN
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              prev_vld_q, prev_vld_d;
  logic [7:0]        rep_q, rep_d;
  logic              hf_q, hf_d;

  // Count consecutive identical pushed words and trip at REP_LIMIT-1 repeats.
  always_comb begin
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    rep_d      = rep_q;
    hf_d       = hf_q;
    trip       = 1'b0;
    if (load) begin
      prev_vld_d = 1'b0;
      rep_d      = '0;
      hf_d       = 1'b0;
    end else if (step) begin
      prev_d     = word;
      prev_vld_d = 1'b1;
      if (prev_vld_q && (word == prev_q)) rep_d = rep_q + 8'd1;
      else                                rep_d = '0;
      if (rep_d == 8'(REP_LIMIT - 1)) begin
        hf_d = 1'b1;
        trip = 1'b1;
      end
    end
  end

  // Health-check control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_vld_q <= 1'b0;
      rep_q      <= '0;
      hf_q       <= 1'b0;
    end else begin
      prev_vld_q <= prev_vld_d;
      rep_q      <= rep_d;
      hf_q       <= hf_d;
    end
  end

  // Last pushed word, only meaningful while prev_vld_q is set.
  always_ff @(posedge clk) begin
    prev_q <= prev_d;
  end

  assign hf_now = hf_q;
`else
  assign hf_now = 1'b0;
  assign trip   = 1'b0;
`endif

endmodule

// File: tb/tb_prng_multi.sv
// Testbench for prng_multi (CHANNELS=2, FIFO_DEPTH=4, REP_LIMIT=4).
// Health-check scenario is compiled only with PRNG_HEALTH_CHECK_EN.
module tb_prng_multi;
  localparam int CH    = 2;
  localparam int DEPTH = 4;
  localparam int RLIM  = 4;
  localparam int DW    = 32 * CH;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable, load, out_ready;
  logic [31:0]   seed;
  logic [DW-1:0] out_data;
  logic          out_valid, health_fail;

  int errors = 0;
  int checks = 0;

  prng_multi #(.CHANNELS(CH), .FIFO_DEPTH(DEPTH), .REP_LIMIT(RLIM)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .seed(seed),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [36:0]   m_casr [CH];
  logic [42:0]   m_lfsr [CH];
  logic [DW-1:0] m_q [$];
  logic [DW-1:0] m_prev;
  bit            m_prev_vld;
  int            m_rep;
  bit            m_hf;

  function automatic logic [36:0] m_casr_nx(input logic [36:0] c);
    return ((c << 1) | (c >> 36)) ^ ((c >> 1) | (c << 36)) ^ (c & 37'h0_0800_0000);
  endfunction

  function automatic logic [42:0] m_lfsr_nx(input logic [42:0] l);
    return ((l << 1) | (l >> 42)) ^ (l[42] ? 43'h200_0010_0002 : 43'h0);
  endfunction

  task automatic m_reset();
    for (int c = 0; c < CH; c++) begin
      m_casr[c] = 37'h10000000;
      m_lfsr[c] = 43'h10000001;
    end
    m_q.delete();
    m_prev_vld = 0;
    m_rep = 0;
    m_hf = 0;
  endtask

  task automatic m_step();
    logic [DW-1:0] w;
    logic [31:0]   s;
    bit            pop, full;
    pop  = (m_q.size() > 0) && out_ready;
    full = (m_q.size() == DEPTH);
    if (load) begin
      for (int c = 0; c < CH; c++) begin
        s = seed ^ (32'(c) * 32'h9E3779B9);
        m_casr[c] = {5'h0, s} | 37'h1000_0000;
        m_lfsr[c] = {11'h0, s} | 43'h1000_0000;
      end
      m_q.delete();
      m_prev_vld = 0;
      m_rep = 0;
      m_hf = 0;
    end else if (enable && !m_hf && (!full || pop)) begin
      for (int c = 0; c < CH; c++) begin
        w[32*c +: 32] = m_lfsr[c][31:0] ^ m_casr[c][31:0];
        m_casr[c] = m_casr_nx(m_casr[c]);
        m_lfsr[c] = m_lfsr_nx(m_lfsr[c]);
      end
      if (pop) void'(m_q.pop_front());
      m_q.push_back(w);
`ifdef PRNG_HEALTH_CHECK_EN
      m_rep = (m_prev_vld && w == m_prev) ? m_rep + 1 : 0;
      m_prev = w;
      m_prev_vld = 1;
      if (m_rep == RLIM - 1) begin
        m_hf = 1;
        m_q.delete();
      end
`endif
    end else if (pop) begin
      void'(m_q.pop_front());
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else        m_step();
  end

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", {63'h0, out_valid}, 64'h0);
      chk("rst_data", out_data, 64'h0);
    end else begin
      chk("valid", {63'h0, out_valid}, {63'h0, m_q.size() > 0});
      if (m_q.size() > 0) chk("data", out_data, m_q[0]);
      chk("health", {63'h0, health_fail}, {63'h0, m_hf});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n = 1'b0; enable = 1'b0; load = 1'b0; seed = '0; out_ready = 1'b0;
    #12;
    chk("reset_valid", {63'h0, out_valid}, 64'h0);
    chk("reset_data", out_data, 64'h0);
    chk("reset_health", {63'h0, health_fail}, 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // First two words after reset.
    enable = 1'b1; out_ready = 1'b1;
    tick();
    chk("first_word", out_data, 64'h00000001_00000001);
    tick();
    chk("second_word", out_data, 64'h08000002_08000002);

    // Mixed enable / ready pattern.
    for (int i = 0; i < 40; i++) begin
      enable    = (i % 7) != 6;
      out_ready = (i % 3) != 0;
      tick();
    end

    // Fill to capacity with the consumer stalled.
    enable = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && out_valid; i++) tick();
    chk("drained", {63'h0, out_valid}, 64'h0);
    out_ready = 1'b0; enable = 1'b1;
    repeat (8) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; enable = 1'b0;
    tick();
    out_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (!out_valid) break;
      n++;
      tick();
    end
    chk("fill_count", 64'(n), 64'd4);

    // Seed load mid-stream with seed 0.
    enable = 1'b1; out_ready = 1'b0;
    repeat (3) tick();
    load = 1'b1; seed = 32'h0;
    tick();
    load = 1'b0; enable = 1'b0;
    chk("load_flush", {63'h0, out_valid}, 64'h0);
    enable = 1'b1; out_ready = 1'b1;
    tick();
    chk("seed0_word0", out_data, 64'h00000000_00000000);
    tick();
    chk("seed0_word1", out_data, 64'h471BBCDC_08000000);

    // Asynchronous reset with three buffered words.
    enable = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && out_valid; i++) tick();
    enable = 1'b1; out_ready = 1'b0;
    repeat (3) tick();
    chk("three_held", {63'h0, out_valid}, 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", {63'h0, out_valid}, 64'h0);
    chk("async_data", out_data, 64'h0);
    repeat (2) @(posedge clk);
    out_ready = 1'b1;
    #1 rst_n = 1'b1;
    tick();
    chk("post_reset_word", out_data, 64'h00000001_00000001);
    chk("health_low", {63'h0, health_fail}, 64'h0);

`ifdef PRNG_HEALTH_CHECK_EN
    // Force a fixed point so every word repeats.
    load = 1'b1; seed = 32'h1234_5678;
    tick();
    load = 1'b0;
    force dut.casr_q = '0;
    force dut.lfsr_q = '0;
    for (int c = 0; c < CH; c++) begin
      m_casr[c] = '0;
      m_lfsr[c] = '0;
    end
    repeat (3) tick();
    chk("hf_before", {63'h0, health_fail}, 64'h0);
    tick();
    chk("hf_set", {63'h0, health_fail}, 64'h1);
    chk("hf_flush", {63'h0, out_valid}, 64'h0);
    release dut.casr_q;
    release dut.lfsr_q;
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("hf_clear", {63'h0, health_fail}, 64'h0);
    repeat (4) tick();
`endif

    enable = 1'b0;
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/prng_multi.md
PRNG_MULTI -- requirements
Module: prng_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, the number of independent LFSR+CASR generator channels (range 1..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, the output buffer depth in words (power of two, 2..64).
REQ-003 SHALL have parameter REP_LIMIT, default 4, the consecutive-repeat count that trips the health check (range 2..255).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port enable, input, 1 bit: permits the generator to step.
REQ-007 SHALL have port load, input, 1 bit: one-cycle seed load strobe.
REQ-008 SHALL have port seed, input, 32 bits: seed value sampled when load=1.
REQ-009 SHALL have port out_data, output, 32*CHANNELS bits: head-of-FIFO random word.
REQ-010 SHALL have port out_valid, output, 1 bit: the FIFO is non-empty.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accept; a pop occurs when out_valid && out_ready.
REQ-012 SHALL have port health_fail, output, 1 bit: sticky health-check failure flag.

Function
REQ-013 Each channel c SHALL hold a CASR of 37 bits and an LFSR of 43 bits.
REQ-014 On a step, the CASR SHALL update as rotl1(CASR) ^ rotr1(CASR) ^ (CASR[27] at bit 27).
REQ-015 On a step, the LFSR SHALL update as rotl1(LFSR) ^ (LFSR[42] placed at bits 41, 20 and 1).
REQ-016 The word for channel c SHALL be LFSR[31:0] ^ CASR[31:0] of the pre-step state, placed at out_data bits [32c+31:32c].
REQ-017 A step SHALL occur when enable && !load && !health_fail && (FIFO not full || pop this cycle); all channels step together, and the concatenated word is pushed into the FIFO in that same cycle.
REQ-018 The FIFO SHALL be first-word-fall-through, so out_valid rises in the cycle after the first push into an empty FIFO.
REQ-019 A simultaneous push and pop SHALL leave the count unchanged, including when the FIFO is full; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-020 With load=1, for each channel c: CASR <= {5'h0, s_c} | 37'h1000_0000 and LFSR <= {11'h0, s_c} | 43'h1000_0000, where s_c = seed ^ (c * 32'h9E37_79B9) truncated to 32 bits.
REQ-021 Load SHALL flush the FIFO (count 0, out_valid low next cycle), clear health_fail and the repeat counter, and take priority over enable and pop.
REQ-022 out_data SHALL be held stable while out_valid=1 and out_ready=0.

Reset
REQ-023 While rst_n=0, every channel SHALL be CASR=37'h10000000 and LFSR=43'h10000001.
REQ-024 While rst_n=0, the FIFO SHALL be empty, out_valid=0, out_data=0, health_fail=0, and the repeat counter=0.
REQ-025 Reset asserted mid-operation SHALL discard buffered words immediately, without waiting for a clock edge.

Configuration
REQ-026 With macro PRNG_HEALTH_CHECK_EN defined, each step SHALL compare the new word with the previous pushed word; a match increments the repeat counter and a mismatch resets it to 0.
REQ-027 With PRNG_HEALTH_CHECK_EN defined, when the repeat counter reaches REP_LIMIT-1, health_fail SHALL set, the FIFO SHALL flush, and stepping SHALL halt until load or reset.
REQ-028 With PRNG_HEALTH_CHECK_EN undefined, the comparator and counter SHALL be absent and health_fail SHALL be tied to 0.

Verification
REQ-029 Reset, CHANNELS=1, enable=1, out_ready=1 -> the first word is 32'h00000001 and the second is 32'h08000002.
REQ-030 FIFO_DEPTH=4, out_ready=0, enable=1 -> exactly 4 pushes, then stall; pulse out_ready for one cycle -> one pop and one refill, with count staying 4.
REQ-031 load with seed=0 mid-stream -> FIFO flushed; channel 0 CASR=37'h10000000 and LFSR=43'h10000000; channel 1 seeded from 32'h9E3779B9|32'h10000000.
REQ-032 PRNG_HEALTH_CHECK_EN defined, force LFSR/CASR to a fixed point by hierarchical override, REP_LIMIT=4 -> health_fail=1 after the 4th identical word, out_valid=0; load clears the flag.
REQ-033 rst_n asserted while the FIFO holds 3 words -> out_valid=0 asynchronously; after release and enable, the first word is 32'h00000001 per channel.
